// File: rtl/parity_engine_ctrl.sv
// Purpose : sequencing FSM for a page-parity engine; walks PAGES pages through
//           load / column-parity / XOR-shift / write-back, optionally re-runs
//           page 0 with the accumulated parity (wrap pass), then streams results.
// Latency : per page 1 (REQ, no stall) + 1 (LOAD) + COLS (PAR) + SLICES (XOR) + 1 (WRITE);
//           wrap pass adds 1 + COLS + SLICES + 1; output phase PAGES beats + 1 (DONE).
// Backpressure: waits indefinitely in REQ for in_valid and in OUT for out_ready,
//           holding every output stable while stalled.
// Ports   : clk, rst (sync, active-high); start/mode/ready job handshake;
//           in_valid/in_ready page input; out_valid/out_ready result output;
//           mem_addr/mem_read/mem_write page memory; reg_*/col_*/par_*/xor_src
//           datapath controls; done one-cycle completion pulse.
module parity_engine_ctrl #(
  parameter  int PAGES  = 5,
  parameter  int COLS   = 5,
  parameter  int SLICES = 64,
  localparam int PW     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  output logic          ready,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic          reg_clr,
  output logic          reg_ld,
  output logic          reg_shr,
  output logic          col_clr,
  output logic          col_shr,
  output logic          par_clr,
  output logic          par_ld,
  output logic          xor_src,
  output logic          done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = (SLICES > 1) ? $clog2(SLICES) : 1;

  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [SW-1:0] SLICE_LAST = SW'(SLICES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_REQ,
    S_LOAD,
    S_PAR,
    S_XOR,
    S_WRITE,
    S_FIRST,
    S_PAR1,
    S_XOR1,
    S_WRITE1,
    S_OUT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] page_cnt;
  logic [CW-1:0] col_cnt;
  logic [SW-1:0] slice_cnt;
  logic          mode_r;

  wire page_last  = (page_cnt == PAGE_LAST);
  wire col_last   = (col_cnt == COL_LAST);
  wire slice_last = (slice_cnt == SLICE_LAST);

  // State register and counters. Counters only move in the states that own
  // them, so they are implicitly held during REQ/OUT stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      page_cnt  <= '0;
      col_cnt   <= '0;
      slice_cnt <= '0;
      mode_r    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) mode_r <= mode;
        end
        S_INIT: page_cnt <= '0;
        S_REQ: begin
          col_cnt   <= '0;
          slice_cnt <= '0;
        end
        S_PAR, S_PAR1: col_cnt <= col_cnt + 1'b1;
        S_XOR, S_XOR1: slice_cnt <= slice_cnt + 1'b1;
        S_WRITE: begin
          // On the last page the wrap pass still needs page_cnt only for
          // nothing (FIRST/WRITE1 address page 0 directly); WRITE1 clears it.
          if (!page_last)   page_cnt <= page_cnt + 1'b1;
          else if (!mode_r) page_cnt <= '0;
        end
        S_FIRST: begin
          col_cnt   <= '0;
          slice_cnt <= '0;
        end
        S_WRITE1: page_cnt <= '0;
        S_OUT: begin
          if (out_ready && !page_last) page_cnt <= page_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state and Moore output decode.
  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_clr   = 1'b0;
    reg_ld    = 1'b0;
    reg_shr   = 1'b0;
    col_clr   = 1'b0;
    col_shr   = 1'b0;
    par_clr   = 1'b0;
    par_ld    = 1'b0;
    xor_src   = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nx = S_INIT;
      end
      S_INIT: state_nx = S_REQ;
      S_REQ: begin
        in_ready = 1'b1;
        reg_clr  = 1'b1;
        col_clr  = 1'b1;
        par_clr  = 1'b1;
        if (in_valid) state_nx = S_LOAD;
      end
      S_LOAD: begin
        reg_ld   = 1'b1;
        state_nx = S_PAR;
      end
      S_PAR: begin
        col_shr = 1'b1;
        if (col_last) state_nx = S_XOR;
      end
      S_XOR: begin
        reg_shr = 1'b1;
        if (slice_last) state_nx = S_WRITE;
      end
      S_WRITE: begin
        mem_write = 1'b1;
        par_ld    = 1'b1;
        mem_addr  = page_cnt;
        if (!page_last)  state_nx = S_REQ;
        else if (mode_r) state_nx = S_FIRST;
        else             state_nx = S_OUT;
      end
      S_FIRST: begin
        // Re-read page 0 so its contents can be folded with the final parity.
        mem_read = 1'b1;
        reg_ld   = 1'b1;
        col_clr  = 1'b1;
        state_nx = S_PAR1;
      end
      S_PAR1: begin
        col_shr = 1'b1;
        if (col_last) state_nx = S_XOR1;
      end
      S_XOR1: begin
        reg_shr = 1'b1;
        xor_src = 1'b1;
        if (slice_last) state_nx = S_WRITE1;
      end
      S_WRITE1: begin
        mem_write = 1'b1;
        state_nx  = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        mem_read  = 1'b1;
        mem_addr  = page_cnt;
        if (out_ready && page_last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: doc/parity_engine_ctrl.md
PARITY_ENGINE_CTRL -- requirements
Module: parity_engine_ctrl

Interface
REQ-001 Parameter PAGES, default 5: number of pages processed per job; legal range 1..16.
REQ-002 Parameter COLS, default 5: column-parity cycles per page; legal range 1..16.
REQ-003 Parameter SLICES, default 64: XOR/shift cycles per page; legal range 1..256.
REQ-004 Derived width PW = max(1, clog2(PAGES)).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  job request, sampled in IDLE only.
REQ-008 mode  input  1  0 = linear pass; 1 = linear pass plus first-page wrap pass; sampled in IDLE together with start.
REQ-009 ready  output  1  high in IDLE.
REQ-010 in_valid / in_ready  input / output  1 each  page-input handshake.
REQ-011 out_valid / out_ready  output / input  1 each  result-output handshake.
REQ-012 mem_addr  output  PW  page address.
REQ-013 mem_read, mem_write  output  1 each  memory strobes.
REQ-014 reg_clr, reg_ld, reg_shr, col_clr, col_shr, par_clr, par_ld, xor_src  output  1 each  datapath controls.
REQ-015 done  output  1  one-cycle job-complete pulse.

Function
REQ-016 Moore FSM with states IDLE, INIT, REQ, LOAD, PAR, XOR, WRITE, FIRST, PAR1, XOR1, WRITE1, OUT, DONE; all outputs decode from state and internal counters only.
REQ-017 Internal counters: page_cnt (PW bits), col_cnt (0..COLS-1), slice_cnt (0..SLICES-1), mode_r (latched mode).
REQ-018 IDLE: ready=1; start=1 -> INIT and latch mode_r; otherwise stay.
REQ-019 INIT, 1 cycle: page_cnt<=0 -> REQ.
REQ-020 REQ: in_ready=1, reg_clr=col_clr=par_clr=1, col_cnt<=0, slice_cnt<=0; leave for LOAD only on the cycle in_valid=1; wait indefinitely otherwise.
REQ-021 LOAD, 1 cycle: reg_ld=1 -> PAR.
REQ-022 PAR: col_shr=1, col_cnt++ each cycle; exits to XOR on the cycle col_cnt==COLS-1, giving exactly COLS cycles.
REQ-023 XOR: reg_shr=1, slice_cnt++; exits to WRITE on slice_cnt==SLICES-1, giving exactly SLICES cycles.
REQ-024 WRITE, 1 cycle: mem_write=1, par_ld=1, mem_addr=page_cnt.
- page_cnt<PAGES-1: page_cnt++ -> REQ.
- page_cnt==PAGES-1 and mode_r=0: page_cnt<=0 -> OUT.
- page_cnt==PAGES-1 and mode_r=1: -> FIRST.
REQ-025 FIRST, 1 cycle: mem_read=1, mem_addr=0, reg_ld=1, col_clr=1; col_cnt<=0, slice_cnt<=0 -> PAR1.
REQ-026 PAR1 behaves as PAR (COLS cycles) -> XOR1.
REQ-027 XOR1 behaves as XOR (SLICES cycles) with xor_src=1 -> WRITE1.
REQ-028 WRITE1, 1 cycle: mem_write=1, mem_addr=0; page_cnt<=0 -> OUT.
REQ-029 OUT: out_valid=1, mem_read=1, mem_addr=page_cnt.
- On the cycle out_ready=1: page_cnt++, or -> DONE if page_cnt==PAGES-1.
- out_ready=0: hold all outputs stable.
REQ-030 DONE, 1 cycle: done=1 -> IDLE.
REQ-031 start outside IDLE is ignored; mode changes outside IDLE have no effect.
REQ-032 With PAGES=1, WRITE always takes its last-page branch; with COLS=1 or SLICES=1, PAR/XOR last exactly 1 cycle.
REQ-033 Strobes not listed for a state are 0 in that state.

Reset
REQ-034 rst=1 at a rising edge forces IDLE and clears page_cnt, col_cnt, slice_cnt and mode_r, from any state including mid-job.
REQ-035 Outputs after reset: ready=1; all others 0; mem_addr=0.

Verification (PAGES=3, COLS=5, SLICES=8)
REQ-036 Mode 0, in_valid=1 and out_ready=1 held: start sampled at edge 0 -> INIT in cycle 1; mem_write pulses at cycles 17, 33 and 49 with mem_addr 0, 1, 2; done in cycle 53; ready=1 in cycle 54.
REQ-037 Mode 1, same stimulus -> FIRST in cycle 50 with mem_addr=0; xor_src=1 for 8 cycles (56..63); WRITE1 in cycle 64; done in cycle 68.
REQ-038 in_valid held 0 for 4 cycles in REQ -> in_ready stays 1 and the FSM stalls in REQ; LOAD follows the in_valid=1 cycle; done is delayed by exactly 4 cycles.
REQ-039 out_ready low for 3 cycles on page 1 in OUT -> out_valid=1 and mem_addr=1 held stable; done is delayed by 3 cycles.
REQ-040 rst pulsed during XOR of page 1, then start=1 -> the new job restarts from page 0 with full PAR/XOR lengths.
REQ-041 start toggled every cycle while busy -> no effect on state sequence or timing.
